// File: rtl/logic_seq_pkg.sv
// Shared definitions for the slice-serial logic unit:
// op encodings and the sequencer FSM state type.
package logic_seq_pkg;

   localparam logic [2:0] OP_AND   = 3'b000;
   localparam logic [2:0] OP_OR    = 3'b001;
   localparam logic [2:0] OP_XOR   = 3'b010;
   localparam logic [2:0] OP_NOR   = 3'b011;
   localparam logic [2:0] OP_ANDN  = 3'b100;
   localparam logic [2:0] OP_PASSA = 3'b101;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/logic_slice.sv
// One SLICE-wide bitwise operation (combinational).
// Ports: a, b operands; op select; y slice result.
module logic_slice
   import logic_seq_pkg::*;
#(
   parameter int SLICE = 8
) (
   input  logic [SLICE-1:0] a,
   input  logic [SLICE-1:0] b,
   input  logic [2:0]       op,
   output logic [SLICE-1:0] y
);

   always_comb begin
      y = '0;
      unique case (1'b1)
         (op == OP_AND):   y = a & b;
         (op == OP_OR):    y = a | b;
         (op == OP_XOR):   y = a ^ b;
         (op == OP_NOR):   y = ~(a | b);
         (op == OP_ANDN):  y = a & ~b;
         (op == OP_PASSA): y = a;
         default:          y = '0;
      endcase
   end

endmodule

// File: rtl/logic_seq_unit.sv
// Slice-serial logic unit: computes a WIDTH-bit bitwise op
// SLICE bits per clock, LSB slice first.
// Ports: clk, rst_n (async low), start/op/a/b request,
// busy, done pulse, result; zero flag with LOGIC_ZERO_FLAG_EN.
module logic_seq_unit
   import logic_seq_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int SLICE = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result
`ifdef LOGIC_ZERO_FLAG_EN
   ,
   output logic             zero
`endif
);

   localparam int N  = WIDTH / SLICE;
   localparam int CW = (N > 1) ? $clog2(N) : 1;

   state_t           state;
   state_t           nstate;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [2:0]       op_q;
   logic [CW-1:0]    cnt;
   logic [SLICE-1:0] y;
   logic [WIDTH-1:0] res_nxt;
   logic             last;
   logic             accept;

   assign last = (cnt == CW'(N - 1));

   logic_slice #(.SLICE(SLICE)) u_slice (
      .a  (a_q[cnt*SLICE +: SLICE]),
      .b  (b_q[cnt*SLICE +: SLICE]),
      .op (op_q),
      .y  (y)
   );

   // Result with the current slice merged in; also feeds the
   // zero flag so it reflects the final value at done.
   always_comb begin
      res_nxt = result;
      res_nxt[cnt*SLICE +: SLICE] = y;
   end

   always_comb begin
      nstate = state;
      busy   = 1'b0;
      done   = 1'b0;
      accept = 1'b0;
      unique case (state)
         IDLE: begin
            if (start) begin
               nstate = RUN;
               accept = 1'b1;
            end
         end
         RUN: begin
            busy = 1'b1;
            if (last) nstate = DONE;
         end
         DONE: begin
            done = 1'b1;
            if (start) begin
               nstate = RUN;
               accept = 1'b1;
            end else begin
               nstate = IDLE;
            end
         end
         default: nstate = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         a_q    <= '0;
         b_q    <= '0;
         op_q   <= '0;
         cnt    <= '0;
         result <= '0;
      end else begin
         state <= nstate;
         if (accept) begin
            a_q    <= a;
            b_q    <= b;
            op_q   <= op;
            cnt    <= '0;
            result <= '0;
         end else if (state == RUN) begin
            result <= res_nxt;
            // Counter parks on the last slice; no wrap.
            if (!last) cnt <= cnt + 1'b1;
         end
      end
   end

`ifdef LOGIC_ZERO_FLAG_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         zero <= 1'b1;
      end else if (state == RUN && last) begin
         zero <= (res_nxt == '0);
      end
   end
`endif

endmodule

// File: tb/tb_logic_seq_unit.sv
// Self-checking bench for logic_seq_unit (32/8 and 16/4).
// Checks zero flag too when LOGIC_ZERO_FLAG_EN is defined.
module tb_logic_seq_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [2:0]  op = '0;
   logic [31:0] a = '0;
   logic [31:0] b = '0;
   logic        busy;
   logic        done;
   logic [31:0] result;

   logic        start16 = 1'b0;
   logic [2:0]  op16 = '0;
   logic [15:0] a16 = '0;
   logic [15:0] b16 = '0;
   logic        busy16;
   logic        done16;
   logic [15:0] result16;

`ifdef LOGIC_ZERO_FLAG_EN
   logic        zero;
   logic        zero16;
`endif

   int checks = 0;
   int errors = 0;

   logic [31:0] sb[$];
   logic [15:0] sb16[$];

   always #5 clk = ~clk;

   logic_seq_unit #(.WIDTH(32), .SLICE(8)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .op     (op),
      .a      (a),
      .b      (b),
      .busy   (busy),
      .done   (done),
      .result (result)
`ifdef LOGIC_ZERO_FLAG_EN
      ,
      .zero   (zero)
`endif
   );

   logic_seq_unit #(.WIDTH(16), .SLICE(4)) dut16 (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start16),
      .op     (op16),
      .a      (a16),
      .b      (b16),
      .busy   (busy16),
      .done   (done16),
      .result (result16)
`ifdef LOGIC_ZERO_FLAG_EN
      ,
      .zero   (zero16)
`endif
   );

   typedef struct {
      logic [2:0]  o;
      logic [31:0] x;
      logic [31:0] y;
      logic [31:0] e;
   } vec_t;

   task automatic chk(input string nm,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Drive a request now; it is sampled on the next edge.
   task automatic issue(input logic [2:0] o,
                        input logic [31:0] x,
                        input logic [31:0] y,
                        input logic [31:0] e);
      start = 1'b1;
      op = o;
      a = x;
      b = y;
      sb.push_back(e);
      @(posedge clk);
      #1;
      start = 1'b0;
      op = 3'($urandom);
      a = $urandom;
      b = $urandom;
   endtask

   // Entered #1 after the sampling edge; leaves in DONE cycle.
   task automatic wait_done(input string nm);
      int lat;
      int bc;
      logic [31:0] e;
      lat = 1;
      bc = 0;
      while (!done && lat < 20) begin
         if (busy) bc++;
         @(posedge clk);
         #1;
         lat++;
      end
      chk({nm, " latency"}, lat, 5);
      chk({nm, " busy cycles"}, bc, 4);
      chk({nm, " busy in done"}, {31'b0, busy}, 0);
      e = sb.pop_front();
      if (done) begin
         chk({nm, " result"}, result, e);
`ifdef LOGIC_ZERO_FLAG_EN
         chk({nm, " zero"}, {31'b0, zero},
             {31'b0, (e == 32'h0)});
`endif
      end
   endtask

   vec_t tv[10];
   vec_t tv16[2];

   initial begin
      int pulses;
      logic [31:0] cap;
      logic [15:0] e16;
      int lat;

      tv[0] = '{3'b000, 32'hF0F01234, 32'hFF00FF00, 32'hF0001200};
      tv[1] = '{3'b001, 32'h00000001, 32'h00000002, 32'h00000003};
      tv[2] = '{3'b010, 32'hAAAAAAAA, 32'h55555555, 32'hFFFFFFFF};
      tv[3] = '{3'b011, 32'h00000000, 32'h00000000, 32'hFFFFFFFF};
      tv[4] = '{3'b011, 32'hFFFFFFFF, 32'h00000000, 32'h00000000};
      tv[5] = '{3'b100, 32'h12345678, 32'h0000FFFF, 32'h12340000};
      tv[6] = '{3'b101, 32'hDEADBEEF, 32'h00001234, 32'hDEADBEEF};
      tv[7] = '{3'b110, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000};
      tv[8] = '{3'b111, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000};
      tv[9] = '{3'b010, 32'h12345678, 32'hFFFFFFFF, 32'hEDCBA987};

      tv16[0] = '{3'b100, 32'hFFFF, 32'h0F0F, 32'hF0F0};
      tv16[1] = '{3'b111, 32'hFFFF, 32'h0F0F, 32'h0000};

      // Reset state
      #12;
      chk("rst busy", {31'b0, busy}, 0);
      chk("rst done", {31'b0, done}, 0);
      chk("rst result", result, 0);
`ifdef LOGIC_ZERO_FLAG_EN
      chk("rst zero", {31'b0, zero}, 1);
`endif
      @(negedge clk);
      rst_n = 1'b1;

      // Table-driven ops
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         issue(tv[i].o, tv[i].x, tv[i].y, tv[i].e);
         wait_done($sformatf("vec%0d", i));
         @(posedge clk);
         #1;
         chk($sformatf("vec%0d pulse", i), {31'b0, done}, 0);
         repeat (3) @(posedge clk);
         #1;
         chk($sformatf("vec%0d hold", i), result, tv[i].e);
      end

      // Start during RUN is ignored
      @(negedge clk);
      issue(3'b001, 32'h1, 32'h2, 32'h3);
      start = 1'b1;
      op = 3'b010;
      a = 32'hFFFFFFFF;
      b = 32'h0;
      repeat (2) @(posedge clk);
      #1;
      start = 1'b0;
      pulses = 0;
      cap = '0;
      for (int k = 0; k < 10; k++) begin
         if (done) begin
            pulses++;
            cap = result;
         end
         @(posedge clk);
         #1;
      end
      chk("ignore pulses", pulses, 1);
      chk("ignore result", cap, sb.pop_front());

      // Back-to-back accept from DONE
      @(negedge clk);
      issue(3'b101, 32'h12345678, 32'h0, 32'h12345678);
      wait_done("b2b first");
      issue(3'b010, 32'hAAAAAAAA, 32'h55555555, 32'hFFFFFFFF);
      wait_done("b2b second");
      @(posedge clk);
      #1;

      // Reset during RUN aborts
      @(negedge clk);
      start = 1'b1;
      op = 3'b000;
      a = 32'hFFFFFFFF;
      b = 32'hFFFFFFFF;
      @(posedge clk);
      #1;
      start = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("abort busy", {31'b0, busy}, 0);
      chk("abort result", result, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      pulses = 0;
      for (int k = 0; k < 10; k++) begin
         if (done) pulses++;
         @(posedge clk);
         #1;
      end
      chk("abort no done", pulses, 0);
      chk("abort idle busy", {31'b0, busy}, 0);

      // First start after reset release
      @(negedge clk);
      issue(3'b000, 32'hF0F01234, 32'hFF00FF00, 32'hF0001200);
      wait_done("post rst");
      @(posedge clk);
      #1;

      // 16-bit instance
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         start16 = 1'b1;
         op16 = tv16[i].o;
         a16 = tv16[i].x[15:0];
         b16 = tv16[i].y[15:0];
         sb16.push_back(tv16[i].e[15:0]);
         @(posedge clk);
         #1;
         start16 = 1'b0;
         a16 = 16'($urandom);
         lat = 1;
         while (!done16 && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
         end
         e16 = sb16.pop_front();
         chk($sformatf("w16 vec%0d latency", i), lat, 5);
         chk($sformatf("w16 vec%0d result", i),
             {16'b0, result16}, {16'b0, e16});
`ifdef LOGIC_ZERO_FLAG_EN
         chk($sformatf("w16 vec%0d zero", i), {31'b0, zero16},
             {31'b0, (e16 == 16'h0)});
`endif
      end

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
